// File: rtl/systolic_result_drain.sv
// ---------------------------------------------------------------------------
// systolic_result_drain
//
// Output stage of the 1xN systolic array. It takes a result vector from the
// array, optionally applies ReLU to it, and stores it in one half of a
// two-tile ping-pong buffer. The stored tile is then packed PACK_NUM
// elements per word and streamed to the output SRAM/DMA port over a
// valid/ready handshake. Because there are two buffers, the array can
// deliver the next tile while the previous one is still waiting on
// memory backpressure.
//
// Ports
//   clk          system clock, rising edge
//   reset_n      asynchronous active-low reset
//   cap_valid    controller offers a result vector this cycle
//   cap_ready    at least one tile buffer is free
//   res_in       signed result vector, BN_NUM elements of BW_ACT bits
//   relu_en      clamp negative elements to zero (sampled at capture)
//   base_addr    word address of the tile's word 0 (sampled at capture)
//   out_valid    out_data/out_addr/out_strb/out_last are valid
//   out_ready    sink accepts the current word
//   out_data     packed word, element j in bits [j*BW_ACT +: BW_ACT]
//   out_addr     word address (base + word index, wraps at 2^ADDR_W)
//   out_strb     byte-lane enables; lanes past BN_NUM are 0
//   out_last     last word of the tile
//   busy         at least one tile buffer is occupied
//   overflow_err sticky flag: a capture was offered while both buffers
//                were full
//   err_clr      clears overflow_err (a new overflow in the same cycle wins)
// ---------------------------------------------------------------------------
module systolic_result_drain #(
    parameter int BN_NUM   = 10,
    parameter int BW_ACT   = 8,
    parameter int PACK_NUM = 4,
    parameter int ADDR_W   = 16
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         cap_valid,
    output logic                         cap_ready,
    input  logic signed [BW_ACT-1:0]     res_in [BN_NUM],
    input  logic                         relu_en,
    input  logic [ADDR_W-1:0]            base_addr,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [PACK_NUM*BW_ACT-1:0]   out_data,
    output logic [ADDR_W-1:0]            out_addr,
    output logic [PACK_NUM-1:0]          out_strb,
    output logic                         out_last,
    output logic                         busy,
    output logic                         overflow_err,
    input  logic                         err_clr
);

    // Number of words per tile, and the width of the word counter.
    localparam int W  = (BN_NUM + PACK_NUM - 1) / PACK_NUM;
    localparam int KW = (W > 1) ? $clog2(W) : 1;

    typedef enum logic {
        IDLE,
        DRAIN
    } state_t;

    state_t            state;
    state_t            state_next;
    logic              wr_ptr;
    logic              rd_ptr;
    logic [1:0]        count;
    logic [1:0]        count_next;
    logic [KW-1:0]     k;
    logic [KW-1:0]     k_next;
    logic              capture;
    logic              xfer;
    logic              last_xfer;

    logic [BW_ACT-1:0] buf_data [2][BN_NUM];
    logic [ADDR_W-1:0] buf_base [2];

    assign cap_ready = (count != 2'd2);
    assign busy      = (count != 2'd0);
    assign capture   = cap_valid && cap_ready;
    assign xfer      = out_valid && out_ready;
    assign last_xfer = xfer && out_last;

    // Occupancy after this cycle. When a capture lands in the same cycle as
    // a tile's final word, the two cancel and the count does not change.
    always_comb begin
        count_next = count;
        case ({capture, last_xfer})
            2'b10:   count_next = count + 2'd1;
            2'b01:   count_next = count - 2'd1;
            default: count_next = count;
        endcase
    end

    // Drain control. The next state is decided from the post-cycle
    // occupancy, so a capture into an empty block produces word 0 in the
    // following cycle, and a buffered tile follows the last word of the
    // previous one without a bubble.
    always_comb begin
        state_next = state;
        k_next     = k;
        case (state)
            IDLE: begin
                k_next = '0;
                if (count_next != 2'd0) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (last_xfer) begin
                    k_next = '0;
                    if (count_next == 2'd0) begin
                        state_next = IDLE;
                    end
                end else if (xfer) begin
                    k_next = k + 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                k_next     = '0;
            end
        endcase
    end

    // Control registers. Resetting count discards any buffered tiles;
    // the tile data itself does not need a reset because nothing is
    // presented while the block is idle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            k            <= '0;
            wr_ptr       <= 1'b0;
            rd_ptr       <= 1'b0;
            count        <= 2'd0;
            overflow_err <= 1'b0;
        end else begin
            state  <= state_next;
            k      <= k_next;
            wr_ptr <= wr_ptr ^ capture;
            rd_ptr <= rd_ptr ^ last_xfer;
            count  <= count_next;
            if (cap_valid && !cap_ready) begin
                overflow_err <= 1'b1;
            end else if (err_clr) begin
                overflow_err <= 1'b0;
            end
        end
    end

    // Tile storage. ReLU is applied on the way in so the drain side only
    // ever moves bytes.
    always_ff @(posedge clk) begin
        if (capture) begin
            for (int i = 0; i < BN_NUM; i++) begin
                buf_data[wr_ptr][i] <= (relu_en && res_in[i][BW_ACT-1]) ? '0 : res_in[i];
            end
            buf_base[wr_ptr] <= base_addr;
        end
    end

    // Output word selection. Everything here depends only on registered
    // state (state, k, rd_ptr, buffer contents), so out_ready never reaches
    // the outputs combinationally and a stalled word stays stable. Lanes
    // beyond the end of the tile carry zero data and a cleared strobe.
    always_comb begin
        out_valid = (state == DRAIN);
        out_data  = '0;
        out_strb  = '0;
        out_addr  = '0;
        out_last  = 1'b0;
        if (state == DRAIN) begin
            out_addr = buf_base[rd_ptr] + ADDR_W'(k);
            out_last = (k == KW'(W - 1));
            for (int w = 0; w < W; w++) begin
                if (k == KW'(w)) begin
                    for (int j = 0; j < PACK_NUM; j++) begin
                        if (w * PACK_NUM + j < BN_NUM) begin
                            out_data[j*BW_ACT +: BW_ACT] = buf_data[rd_ptr][w*PACK_NUM+j];
                            out_strb[j]                  = 1'b1;
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_systolic_result_drain.sv
// ---------------------------------------------------------------------------
// tb_systolic_result_drain
//
// Directed bench for systolic_result_drain with default parameters
// (10 elements, 8 bits, 4 per word, 16-bit addresses => 3 words per tile).
// Inputs are driven on the falling edge and outputs are checked on the
// falling edge, i.e. half a cycle after the rising edge that produced them.
// ---------------------------------------------------------------------------
module tb_systolic_result_drain;

    logic              clk;
    logic              reset_n;
    logic              cap_valid;
    logic              cap_ready;
    logic signed [7:0] res_in [10];
    logic              relu_en;
    logic [15:0]       base_addr;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_data;
    logic [15:0]       out_addr;
    logic [3:0]        out_strb;
    logic              out_last;
    logic              busy;
    logic              overflow_err;
    logic              err_clr;

    int tests_run;
    int tests_failed;

    systolic_result_drain dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .cap_valid    (cap_valid),
        .cap_ready    (cap_ready),
        .res_in       (res_in),
        .relu_en      (relu_en),
        .base_addr    (base_addr),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_addr     (out_addr),
        .out_strb     (out_strb),
        .out_last     (out_last),
        .busy         (busy),
        .overflow_err (overflow_err),
        .err_clr      (err_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to the next falling edge (drive/sample point).
    task automatic step();
        @(negedge clk);
    endtask

    // One comparison: count it, and on mismatch count the failure and report.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        tests_run++;
        assert (observed === expected)
        else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Check every field of the word currently presented.
    task automatic checkWord(input string tag, input logic [31:0] data,
                             input logic [15:0] addr, input logic [3:0] strb,
                             input logic last);
        checkOutput({tag, "_valid"}, 32'(out_valid), 32'd1);
        checkOutput({tag, "_data"},  out_data,       data);
        checkOutput({tag, "_addr"},  32'(out_addr),  32'(addr));
        checkOutput({tag, "_strb"},  32'(out_strb),  32'(strb));
        checkOutput({tag, "_last"},  32'(out_last),  32'(last));
    endtask

    // Offer a capture of the vector first, first+1, ... first+9.
    task automatic applyStimulus(input logic [7:0] first, input logic [15:0] base,
                                 input logic relu);
        for (int i = 0; i < 10; i++) begin
            res_in[i] = first + 8'(i);
        end
        base_addr = base;
        relu_en   = relu;
        cap_valid = 1'b1;
    endtask

    // Expect a full 3-word tile on consecutive cycles with out_ready=1.
    task automatic expectTile(input string tag, input logic [31:0] d0,
                              input logic [31:0] d1, input logic [31:0] d2,
                              input logic [15:0] base);
        checkWord({tag, "_w0"}, d0, base,         4'b1111, 1'b0);
        step();
        checkWord({tag, "_w1"}, d1, base + 16'd1, 4'b1111, 1'b0);
        step();
        checkWord({tag, "_w2"}, d2, base + 16'd2, 4'b0011, 1'b1);
        step();
    endtask

    initial begin
        logic [31:0] bp_words [3];
        logic [11:0] ready_pat;
        int          exp_k;
        int          transfers;

        tests_run    = 0;
        tests_failed = 0;
        reset_n      = 1'b0;
        cap_valid    = 1'b0;
        relu_en      = 1'b0;
        base_addr    = '0;
        out_ready    = 1'b0;
        err_clr      = 1'b0;
        for (int i = 0; i < 10; i++) res_in[i] = '0;

        // Reset values
        #1;
        checkOutput("rst_valid",     32'(out_valid),    32'd0);
        checkOutput("rst_data",      out_data,          32'd0);
        checkOutput("rst_addr",      32'(out_addr),     32'd0);
        checkOutput("rst_strb",      32'(out_strb),     32'd0);
        checkOutput("rst_busy",      32'(busy),         32'd0);
        checkOutput("rst_cap_ready", 32'(cap_ready),    32'd1);
        checkOutput("rst_overflow",  32'(overflow_err), 32'd0);
        step();
        reset_n = 1'b1;
        step();

        // Basic packing: 1..10 at 0x0100
        out_ready = 1'b1;
        applyStimulus(8'd1, 16'h0100, 1'b0);
        step();
        cap_valid = 1'b0;
        expectTile("basic", 32'h04030201, 32'h08070605, 32'h00000A09, 16'h0100);
        checkOutput("basic_idle_valid", 32'(out_valid), 32'd0);
        checkOutput("basic_idle_busy",  32'(busy),      32'd0);

        // ReLU enabled: -5 clamps to 0
        for (int i = 0; i < 10; i++) res_in[i] = 8'sd1;
        res_in[0] = -8'sd5;
        base_addr = 16'h0000;
        relu_en   = 1'b1;
        cap_valid = 1'b1;
        step();
        cap_valid = 1'b0;
        expectTile("relu_on", 32'h01010100, 32'h01010101, 32'h00000101, 16'h0000);

        // ReLU disabled: -5 passes through as 0xFB
        relu_en   = 1'b0;
        cap_valid = 1'b1;
        step();
        cap_valid = 1'b0;
        expectTile("relu_off", 32'h010101FB, 32'h01010101, 32'h00000101, 16'h0000);
        checkOutput("relu_idle_valid", 32'(out_valid), 32'd0);

        // Backpressure: fixed stall pattern, word must hold while stalled
        bp_words[0] = 32'h04030201;
        bp_words[1] = 32'h08070605;
        bp_words[2] = 32'h00000A09;
        ready_pat   = 12'b0001_0001_0100;
        out_ready   = 1'b0;
        applyStimulus(8'd1, 16'h0200, 1'b0);
        step();
        cap_valid = 1'b0;
        exp_k     = 0;
        transfers = 0;
        for (int c = 0; c < 12 && exp_k < 3; c++) begin
            checkWord($sformatf("bp%0d", c), bp_words[exp_k], 16'h0200 + 16'(exp_k),
                      (exp_k == 2) ? 4'b0011 : 4'b1111, exp_k == 2);
            out_ready = ready_pat[c];
            step();
            if (ready_pat[c]) begin
                exp_k++;
                transfers++;
            end
        end
        checkOutput("bp_transfers", 32'(transfers), 32'd3);
        checkOutput("bp_done_valid", 32'(out_valid), 32'd0);
        checkOutput("bp_done_busy",  32'(busy),      32'd0);

        // Ping-pong and overflow: A, B accepted, C dropped
        out_ready = 1'b0;
        applyStimulus(8'h10, 16'h0300, 1'b0);
        step();
        checkOutput("pp_ready_after_a", 32'(cap_ready), 32'd1);
        applyStimulus(8'h20, 16'h0400, 1'b0);
        step();
        checkOutput("pp_ready_after_b", 32'(cap_ready), 32'd0);
        checkOutput("pp_busy",          32'(busy),      32'd1);
        applyStimulus(8'h30, 16'h0500, 1'b0);
        step();
        cap_valid = 1'b0;
        checkOutput("pp_overflow_set", 32'(overflow_err), 32'd1);
        checkWord("pp_hold", 32'h13121110, 16'h0300, 4'b1111, 1'b0);
        cap_valid = 1'b1;
        err_clr   = 1'b1;
        step();
        cap_valid = 1'b0;
        checkOutput("pp_set_wins", 32'(overflow_err), 32'd1);
        step();
        err_clr = 1'b0;
        checkOutput("pp_overflow_clr", 32'(overflow_err), 32'd0);
        out_ready = 1'b1;
        expectTile("pp_a", 32'h13121110, 32'h17161514, 32'h00001918, 16'h0300);
        expectTile("pp_b", 32'h23222120, 32'h27262524, 32'h00002928, 16'h0400);
        checkOutput("pp_idle_valid", 32'(out_valid), 32'd0);
        checkOutput("pp_idle_busy",  32'(busy),      32'd0);

        // Address wrap, plus a capture in the same cycle as the final word
        applyStimulus(8'd1, 16'hFFFF, 1'b0);
        step();
        cap_valid = 1'b0;
        checkWord("wrap_w0", 32'h04030201, 16'hFFFF, 4'b1111, 1'b0);
        step();
        checkWord("wrap_w1", 32'h08070605, 16'h0000, 4'b1111, 1'b0);
        step();
        checkWord("wrap_w2", 32'h00000A09, 16'h0001, 4'b0011, 1'b1);
        applyStimulus(8'h40, 16'h0600, 1'b0);
        step();
        cap_valid = 1'b0;
        checkOutput("simul_cap_ready", 32'(cap_ready), 32'd1);
        checkOutput("simul_busy",      32'(busy),      32'd1);
        expectTile("simul", 32'h43424140, 32'h47464544, 32'h00004948, 16'h0600);
        checkOutput("simul_idle_busy", 32'(busy), 32'd0);

        // Reset mid-drain with both buffers full
        out_ready = 1'b0;
        applyStimulus(8'h50, 16'h0700, 1'b0);
        step();
        applyStimulus(8'h60, 16'h0800, 1'b0);
        step();
        cap_valid = 1'b0;
        checkOutput("mid_cap_ready", 32'(cap_ready), 32'd0);
        checkOutput("mid_valid",     32'(out_valid), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("arst_valid",     32'(out_valid), 32'd0);
        checkOutput("arst_data",      out_data,       32'd0);
        checkOutput("arst_addr",      32'(out_addr),  32'd0);
        checkOutput("arst_strb",      32'(out_strb),  32'd0);
        checkOutput("arst_last",      32'(out_last),  32'd0);
        checkOutput("arst_busy",      32'(busy),      32'd0);
        checkOutput("arst_cap_ready", 32'(cap_ready), 32'd1);
        step();
        reset_n   = 1'b1;
        out_ready = 1'b1;
        step();
        step();
        checkOutput("post_rst_valid", 32'(out_valid), 32'd0);
        checkOutput("post_rst_busy",  32'(busy),      32'd0);
        checkOutput("post_rst_data",  out_data,       32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
